bit_serializer: RTL
===================

Name: bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the serial pattern-detector FSMs and produces their 1-bit `in` stream.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock.
- Marks each live bit with a strobe.
- Holds the line at a defined idle level between words, so the detector never sees spurious zeros.

Parameters:
- WIDTH, 8: data word width in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 1: value driven on sout when no word is being sent.
- GAP, 2: number of idle cycles inserted after each word; legal range ≥ 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to send.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit stream, registered.
- sout_valid  output  1  high while sout carries a data bit, registered.
- busy  output  1  high in S_SHIFT or S_GAP.

Behaviour:
- Reset: clr=0 forces the following immediately, regardless of clk:
  - state = S_IDLE
  - sout = IDLE_LEVEL, sout_valid = 0, busy = 0
  - shift register = 0, bit counter = 0, gap counter = 0
- Reset mid-frame aborts the word; no partial-word resume after clr releases.
- Handshake:
  - A transfer occurs on a rising edge where din_valid && din_ready.
  - din is sampled only on that edge. While din_valid is low, din is ignored.
  - din_valid may stay high while din_ready is low; nothing is captured and nothing is lost.
- din_ready is decoded combinationally from state and counters only, never from din_valid. It is high:
  - in S_IDLE;
  - in the last S_SHIFT cycle (bit counter == WIDTH-1) when GAP == 0.
- States:
  - S_IDLE: sout = IDLE_LEVEL, sout_valid = 0. On transfer: load the shift register, clear the bit counter, go to S_SHIFT.
  - S_SHIFT: sout = current first-order bit, sout_valid = 1. Each edge shifts one bit and increments the bit counter. At bit counter == WIDTH-1:
    - GAP > 0: go to S_GAP and clear the gap counter.
    - GAP == 0 with a transfer on that edge: reload and stay in S_SHIFT.
    - GAP == 0 with no transfer: go to S_IDLE.
  - S_GAP: sout = IDLE_LEVEL, sout_valid = 0. Go to S_IDLE after exactly GAP cycles in S_GAP.
- Timing: transfer on edge k (state S_IDLE) gives:
  - data bits on sout during cycles k+1 .. k+WIDTH;
  - idle during k+WIDTH+1 .. k+WIDTH+GAP;
  - din_ready high again in cycle k+WIDTH+GAP+1.
  - Steady-state throughput is one word per WIDTH+GAP+1 cycles, or WIDTH cycles when GAP == 0 with back-to-back transfers.
- Width rules:
  - bit counter is $clog2(WIDTH) bits.
  - gap counter is max(1, $clog2(GAP+1)) bits.
  - Neither counter ever exceeds its terminal value.
  - The shift register shifts in IDLE_LEVEL at the vacated end.
- All outputs except din_ready are registered; no combinational path from din_valid to sout.

Decomposition:
- Package ser_pkg holds:
  - typedef enum logic [1:0] state_t {S_IDLE, S_SHIFT, S_GAP};
  - localparam-helper function for counter widths.
- Single module; no sub-module is natural. Counters and the shift register stay inline.

Test Plan:
- Reset: hold clr=0 for 3 cycles with din_valid=1 → sout=1, sout_valid=0, din_ready stays 1 and no capture occurs; release clr → first transfer happens on the next edge.
- Single word, WIDTH=8, MSB_FIRST=1, GAP=2, din=8'h20:
  - sout = 0,0,1,0,0,0,0,0 with sout_valid=1 for 8 cycles;
  - then 1,1 with sout_valid=0;
  - din_ready returns 11 cycles after the transfer edge;
  - a downstream 001 detector asserts once.
- LSB-first, MSB_FIRST=0, din=8'hA5 → sout = 1,0,1,0,0,1,0,1.
- Back-to-back, GAP=0, din_valid held high with 8'hFF then 8'h00 → 16 contiguous sout_valid=1 cycles (eight 1s, then eight 0s), no idle cycle between words.
- Stall: din_valid high during S_SHIFT/S_GAP with din changing every cycle → only the value present on the edge where din_ready=1 is transmitted.
- Mid-frame reset: assert clr after 3 bits of 8'h0F → sout=IDLE_LEVEL and busy=0 immediately, asynchronously; after release, state is S_IDLE and no remaining bits are sent.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial stage.
package ser_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  // Bits needed to count through n_states values; never less than one bit.
  function automatic int cnt_width(input int n_states);
    return (n_states <= 2) ? 1 : $clog2(n_states);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: takes a WIDTH-bit word over valid/ready, shifts it out one
// bit per clock with a strobe, and parks the line at IDLE_LEVEL between words.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter int GAP        = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int BCW = cnt_width(WIDTH);
  localparam int GCW = cnt_width(GAP + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LAST = (GAP > 0) ? GCW'(GAP - 1) : '0;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BCW-1:0]   r_bit_cnt;
  logic [GCW-1:0]   r_gap_cnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [BCW-1:0]   w_bit_cnt_nxt;
  logic [GCW-1:0]   w_gap_cnt_nxt;
  logic             w_last_bit;
  logic             w_ready;
  logic             w_xfer;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], IDLE_LEVEL} : {IDLE_LEVEL, v[WIDTH-1:1]};
  endfunction

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Handshake: a word moves on a rising edge with din_valid && din_ready. din_ready
  // depends only on state and counters (never on din_valid), so a held din_valid while
  // not ready is simply waited on; din is looked at only on the transfer edge.
  assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == BIT_LAST);
  assign w_ready    = (r_state == S_IDLE) || ((GAP == 0) && w_last_bit);
  assign w_xfer     = din_valid && w_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_shift_nxt   = din;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift_nxt = shift_one(r_shift);
        if (!w_last_bit) begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end else begin
          w_bit_cnt_nxt = '0;
          if (GAP > 0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = '0;
          end else if (w_xfer) begin
            w_shift_nxt = din;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt   = S_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so sout lines up with the state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_sout       <= (w_state_nxt == S_SHIFT) ? first_bit(w_shift_nxt) : IDLE_LEVEL;
      r_sout_valid <= (w_state_nxt == S_SHIFT);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign din_ready  = w_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule
